// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions for the hazard/stall control slice.
package hazard_stall_unit_pkg;

  localparam int PIPE_REG_ADDR_W = 5;
  localparam logic [PIPE_REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hazState_t;

endpackage

// File: rtl/hazard_stall_unit_hazard_compare.sv
// Combinational operand-dependency check between the ID instruction and the EX instruction.
module hazard_compare
  import hazard_stall_unit_pkg::*;
#(
  parameter int REG_ADDR_W = PIPE_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] idRs,
  input  logic [REG_ADDR_W-1:0] idRt,
  input  logic                  idUsesRt,
  input  logic                  idIsBranch,
  input  logic                  exMemRead,
  input  logic                  exRegWrite,
  input  logic [REG_ADDR_W-1:0] exDest,
  output logic                  loadHz,
  output logic                  aluBrHz
);

  logic dep;

  // $zero never carries a real dependency.
  assign dep = (exDest != REG_ADDR_W'(REG_ZERO)) &&
               ((exDest == idRs) || (idUsesRt && (exDest == idRt)));

  assign loadHz  = exMemRead && dep;
  assign aluBrHz = idIsBranch && exRegWrite && !exMemRead && dep;

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline-control side of hazard handling: bubble select, PC/IF-ID enables, IF/ID flush, stall counter.
//   state | meaning
//   RUN   | normal issue; a hazard seen here stalls this cycle combinationally
//   STALL | extra stall cycles remaining in cnt; hazard inputs ignored
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int REG_ADDR_W         = PIPE_REG_ADDR_W,
  parameter int STALL_CNT_W        = 2,
  parameter int LOAD_BRANCH_STALLS = 2,
  parameter int ALU_BRANCH_STALLS  = 1,
  parameter int PERF_W             = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [REG_ADDR_W-1:0] ifid_rs,
  input  logic [REG_ADDR_W-1:0] ifid_rt,
  input  logic                  ifid_uses_rt,
  input  logic                  ifid_is_branch,
  input  logic                  branch_taken,
  input  logic                  idex_mem_read,
  input  logic                  idex_reg_write,
  input  logic [REG_ADDR_W-1:0] idex_dest,
  input  logic                  freeze,
  output logic                  ctrl_enable,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  stall_active,
  output logic [PERF_W-1:0]     stall_cycles
);

  hazState_t               state;
  logic [STALL_CNT_W-1:0]  cnt;
  logic [PERF_W-1:0]       perf;
  logic [STALL_CNT_W-1:0]  stallLen;
  logic                    loadHz;
  logic                    aluBrHz;
  logic                    hazard;
  logic                    stalling;

  hazard_compare #(.REG_ADDR_W(REG_ADDR_W)) uCompare (
    .idRs       (ifid_rs),
    .idRt       (ifid_rt),
    .idUsesRt   (ifid_uses_rt),
    .idIsBranch (ifid_is_branch),
    .exMemRead  (idex_mem_read),
    .exRegWrite (idex_reg_write),
    .exDest     (idex_dest),
    .loadHz     (loadHz),
    .aluBrHz    (aluBrHz)
  );

  always_comb begin
    stallLen = '0;
    if (loadHz)
      stallLen = ifid_is_branch ? STALL_CNT_W'(LOAD_BRANCH_STALLS) : STALL_CNT_W'(1);
    else if (aluBrHz)
      stallLen = STALL_CNT_W'(ALU_BRANCH_STALLS);
  end

  assign hazard   = reset_n && !freeze && (state == RUN) && (loadHz || aluBrHz);
  assign stalling = hazard || (reset_n && (state == STALL));

  // Outputs stay combinational so a stall bites in the detection cycle.
  assign ctrl_enable  = reset_n && !freeze && !stalling;
  assign pc_write     = ctrl_enable;
  assign ifid_write   = ctrl_enable;
  assign ifid_flush   = ctrl_enable && branch_taken;
  assign stall_active = stalling;
  assign stall_cycles = perf;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
      cnt   <= '0;
      perf  <= '0;
    end else if (!freeze) begin
      if (stalling)
        perf <= perf + PERF_W'(1);
      case (state)
        RUN: begin
          if (hazard && (stallLen > STALL_CNT_W'(1))) begin
            cnt   <= stallLen - STALL_CNT_W'(1);
            state <= STALL;
          end
        end
        STALL: begin
          if (cnt <= STALL_CNT_W'(1)) begin
            cnt   <= '0;
            state <= RUN;
          end else begin
            cnt <= cnt - STALL_CNT_W'(1);
          end
        end
        default: begin
          cnt   <= '0;
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: directed scenarios then random traffic against a cycle-level model.
module tb_hazard_stall_unit;

  localparam int LBS = 2;
  localparam int ABS = 1;

  typedef struct {
    logic       rstN;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       usesRt;
    logic       isBranch;
    logic       taken;
    logic       memRead;
    logic       regWrite;
    logic [4:0] dest;
    logic       frz;
  } stim_t;

  typedef struct {
    logic [4:0]  flags;
    logic [31:0] perf;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  ifid_rs = '0, ifid_rt = '0, idex_dest = '0;
  logic        ifid_uses_rt = 1'b0, ifid_is_branch = 1'b0, branch_taken = 1'b0;
  logic        idex_mem_read = 1'b0, idex_reg_write = 1'b0, freeze = 1'b0;
  logic        ctrl_enable, pc_write, ifid_write, ifid_flush, stall_active;
  logic [31:0] stall_cycles;

  int checks = 0;
  int errors = 0;
  exp_t expQ[$];

  // Model: remaining stall cycles and bubble count.
  int          mRemain = 0;
  logic [31:0] mPerf = '0;

  hazard_stall_unit #(
    .REG_ADDR_W(5), .STALL_CNT_W(2), .LOAD_BRANCH_STALLS(LBS),
    .ALU_BRANCH_STALLS(ABS), .PERF_W(32)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .ifid_is_branch(ifid_is_branch), .branch_taken(branch_taken),
    .idex_mem_read(idex_mem_read), .idex_reg_write(idex_reg_write),
    .idex_dest(idex_dest), .freeze(freeze),
    .ctrl_enable(ctrl_enable), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .stall_active(stall_active), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic stim_t bubble();
    stim_t s;
    s.rstN = 1'b1; s.rs = 5'd1; s.rt = 5'd2; s.usesRt = 1'b1; s.isBranch = 1'b0;
    s.taken = 1'b0; s.memRead = 1'b0; s.regWrite = 1'b0; s.dest = 5'd0; s.frz = 1'b0;
    return s;
  endfunction

  function automatic exp_t model(stim_t s);
    exp_t e;
    int   n;
    logic dep;
    if (!s.rstN) begin
      mRemain = 0;
      mPerf   = '0;
      e.flags = 5'b00000;
      e.perf  = '0;
      return e;
    end
    e.perf = mPerf;
    if (s.frz) begin
      e.flags = {4'b0000, (mRemain > 0)};
    end else if (mRemain > 0) begin
      e.flags = 5'b00001;
      mRemain--;
      mPerf++;
    end else begin
      dep = (s.dest != 0) && ((s.dest == s.rs) || (s.usesRt && (s.dest == s.rt)));
      n = 0;
      if (s.memRead && dep) n = s.isBranch ? LBS : 1;
      else if (s.isBranch && s.regWrite && dep) n = ABS;
      if (n > 0) begin
        e.flags = 5'b00001;
        mPerf++;
        mRemain = n - 1;
      end else begin
        e.flags = {3'b111, s.taken, 1'b0};
      end
    end
    return e;
  endfunction

  // Drive one cycle's inputs shortly after the edge and queue the expected response.
  task automatic step(input stim_t s);
    @(posedge clk);
    #1;
    reset_n = s.rstN; ifid_rs = s.rs; ifid_rt = s.rt; ifid_uses_rt = s.usesRt;
    ifid_is_branch = s.isBranch; branch_taken = s.taken; idex_mem_read = s.memRead;
    idex_reg_write = s.regWrite; idex_dest = s.dest; freeze = s.frz;
    expQ.push_back(model(s));
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [4:0] act;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      act = {ctrl_enable, pc_write, ifid_write, ifid_flush, stall_active};
      checks++;
      if (act !== e.flags) begin
        errors++;
        $display("FAIL flags t=%0t got %b want %b (ce,pcw,ifw,flush,sa)", $time, act, e.flags);
      end
      checks++;
      if (stall_cycles !== e.perf) begin
        errors++;
        $display("FAIL stall_cycles t=%0t got %0d want %0d", $time, stall_cycles, e.perf);
      end
    end
  end

  initial begin
    stim_t s;
    stim_t ldBr;
    ldBr = bubble();
    ldBr.memRead = 1'b1; ldBr.dest = 5'd9; ldBr.rt = 5'd9; ldBr.rs = 5'd3;
    ldBr.usesRt = 1'b1; ldBr.isBranch = 1'b1; ldBr.taken = 1'b1;

    s = bubble(); s.rstN = 1'b0; step(s); step(s);
    step(bubble());
    // load-use, single bubble
    s = bubble(); s.memRead = 1'b1; s.dest = 5'd8; s.rs = 5'd8; step(s);
    step(bubble());
    // load feeding a branch: two bubbles, taken ignored while stalled
    step(ldBr);
    s = bubble(); s.taken = 1'b1; step(s);
    step(bubble());
    // $zero and unused-rt matches are not hazards
    s = bubble(); s.memRead = 1'b1; s.dest = 5'd0; s.rs = 5'd0; step(s);
    s = bubble(); s.memRead = 1'b1; s.dest = 5'd7; s.rt = 5'd7; s.usesRt = 1'b0; step(s);
    // ALU result feeding a branch
    s = bubble(); s.regWrite = 1'b1; s.dest = 5'd4; s.rs = 5'd4; s.isBranch = 1'b1; step(s);
    // taken branch flush, then taken during a load-use stall
    s = bubble(); s.taken = 1'b1; step(s);
    s = bubble(); s.memRead = 1'b1; s.dest = 5'd8; s.rs = 5'd8; s.taken = 1'b1; step(s);
    step(bubble());
    // freeze while one STALL cycle remains
    step(ldBr);
    s = bubble(); s.frz = 1'b1; s.memRead = 1'b1; s.dest = 5'd5; s.rs = 5'd5;
    step(s); step(s); step(s);
    step(bubble()); step(bubble());
    // asynchronous reset in the middle of a stall
    step(ldBr);
    s = bubble(); s.rstN = 1'b0; step(s);
    s = bubble(); s.taken = 1'b1; step(s);
    step(bubble());

    for (int i = 0; i < 3000; i++) begin
      s.rstN     = ($urandom_range(0, 99) != 0);
      s.rs       = 5'($urandom_range(0, 3));
      s.rt       = 5'($urandom_range(0, 3));
      s.dest     = 5'($urandom_range(0, 3));
      s.usesRt   = 1'($urandom_range(0, 1));
      s.isBranch = 1'($urandom_range(0, 1));
      s.taken    = ($urandom_range(0, 2) == 0);
      s.memRead  = 1'($urandom_range(0, 1));
      s.regWrite = 1'($urandom_range(0, 1));
      s.frz      = ($urandom_range(0, 9) == 0);
      step(s);
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left %0d want 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
- Generates the pipeline-control side of hazard handling for the 5-stage MIPS core: the select line for the ID-stage control-zeroing mux, PC/IF-ID write enables and the IF/ID flush.
- Detects load-use and branch-operand hazards in ID and holds a multi-cycle stall with an internal counter.
- Issues a one-cycle IF/ID flush on taken branches/jumps resolved in ID.
- Keeps a running stall-cycle performance counter.

Parameters:
REG_ADDR_W, 5, register specifier width
STALL_CNT_W, 2, width of internal stall-remaining counter
LOAD_BRANCH_STALLS, 2, stall cycles when an ID branch depends on a load in EX (1..2^STALL_CNT_W-1)
ALU_BRANCH_STALLS, 1, stall cycles when an ID branch depends on an ALU result in EX
PERF_W, 32, stall performance counter width

Ports:
clk  in  1  core clock
reset_n  in  1  asynchronous active-low reset
ifid_rs  in  REG_ADDR_W  rs of instruction in ID
ifid_rt  in  REG_ADDR_W  rt of instruction in ID
ifid_uses_rt  in  1  ID instruction reads rt
ifid_is_branch  in  1  ID instruction is beq/bne (operands compared in ID)
branch_taken  in  1  ID branch/jump resolved taken this cycle
idex_mem_read  in  1  EX instruction is a load
idex_reg_write  in  1  EX instruction writes a register
idex_dest  in  REG_ADDR_W  destination register of EX instruction
freeze  in  1  external hold (memory wait/debug); freezes unit and pipeline
ctrl_enable  out  1  mux select: 1 pass ID control, 0 insert bubble
pc_write  out  1  PC load enable
ifid_write  out  1  IF/ID register load enable
ifid_flush  out  1  clear IF/ID to NOP at next edge
stall_active  out  1  unit in STALL state or stalling this cycle
stall_cycles  out  PERF_W  count of bubble cycles since reset

Behaviour:
- Reset (reset_n low, async): state RUN, counter 0, stall_cycles 0; outputs forced ctrl_enable=0, pc_write=0, ifid_write=0, ifid_flush=0, stall_active=0 while reset_n low.
- dep = idex_dest!=0 && (idex_dest==ifid_rs || (ifid_uses_rt && idex_dest==ifid_rt)).
- load_hz = idex_mem_read && dep; alu_br_hz = ifid_is_branch && idex_reg_write && !idex_mem_read && dep.
- Required stall length N: load_hz && ifid_is_branch -> LOAD_BRANCH_STALLS; load_hz otherwise -> 1; alu_br_hz -> ALU_BRANCH_STALLS.
- State RUN, no hazard: ctrl_enable=1, pc_write=1, ifid_write=1, ifid_flush=branch_taken.
- State RUN, hazard detected:
  - Same cycle (combinational): ctrl_enable=0, pc_write=0, ifid_write=0, ifid_flush=0, stall_active=1.
  - If N>1: counter<=N-1, state<=STALL; otherwise stay RUN.
- State STALL: same outputs as stalled cycle; counter decrements each edge; at counter==1 the next state is RUN. Hazard inputs ignored in STALL (EX holds a bubble).
- branch_taken ignored whenever ctrl_enable=0 (operands not yet valid); no flush during a stall.
- freeze=1 (highest priority after reset):
  - Outputs: pc_write=0, ifid_write=0, ctrl_enable=0, ifid_flush=0.
  - State, counter and stall_cycles hold.
  - Hazard detection suppressed.
- stall_cycles increments by 1 on every edge where ctrl_enable=0 due to a hazard (not freeze); wraps modulo 2^PERF_W.
- Latency: stall assertion is zero-cycle (same cycle as detection); release is registered.
- Reset mid-stall: returns to RUN, counter cleared, next instruction proceeds unstalled.

Decomposition:
- Shared pipeline package: REG_ADDR_W, register-zero constant, hazard-state encoding (RUN, STALL).
- One sub-module: hazard_compare (pure combinational dep/load_hz/alu_br_hz). FSM, counter and perf counter stay in the top.

Test Plan:
- Load-use: idex_mem_read=1, idex_dest=8, ifid_rs=8, ifid_is_branch=0 -> one cycle ctrl_enable=pc_write=ifid_write=0, stall_cycles 0->1, then RUN.
- Load-branch: idex_mem_read=1, idex_dest=9, ifid_rt=9, ifid_uses_rt=1, ifid_is_branch=1; EX inputs return to bubble next cycle -> two stall cycles (cycle 1 combinational, cycle 2 STALL), stall_cycles=2.
- Zero-register and no-rt cases:
  - idex_dest=0 with matching rs -> no stall.
  - ifid_uses_rt=0 with rt match -> no stall.
- Branch flush: RUN, no hazard, branch_taken=1 -> ifid_flush=1 for exactly that cycle. Same branch_taken during a stall -> ifid_flush=0.
- Freeze mid-STALL: freeze=1 for 3 cycles at counter=1 -> counter and stall_cycles hold, all enables 0. After release, one more stall cycle, then RUN.
- Reset mid-STALL: reset_n low asynchronously -> outputs drop to 0 immediately. After release: RUN, stall_cycles=0, ctrl_enable=1 on first cycle.
